// File: rtl/full_logic_drain_if.sv
// Bundle of the full_logic_drain control, FIFO-side and receive-side signals.
// slave is the drain block's view; master is the surrounding environment.
interface full_logic_drain_if #(
  parameter int data_width    = 6,
  parameter int address_width = 2
);
  logic                   init;
  logic [address_width:0] umbral_rx;
  logic [data_width-1:0]  data_out_D0;
  logic [data_width-1:0]  data_out_D1;
  logic                   empty_fifo_D0;
  logic                   empty_fifo_D1;
  logic                   error_D0;
  logic                   error_D1;
  logic                   rd_pop;
  logic                   D0_pop;
  logic                   D1_pop;
  logic [data_width-1:0]  data_rx;
  logic                   src_rx;
  logic                   empty_rx;
  logic                   almost_full_rx;
  logic [7:0]             count_D0;
  logic [7:0]             count_D1;
  logic                   idle_out;
  logic                   active_out;
  logic                   error_out;

  modport slave (
    input  init, umbral_rx, data_out_D0, data_out_D1, empty_fifo_D0, empty_fifo_D1,
           error_D0, error_D1, rd_pop,
    output D0_pop, D1_pop, data_rx, src_rx, empty_rx, almost_full_rx,
           count_D0, count_D1, idle_out, active_out, error_out
  );

  modport master (
    output init, umbral_rx, data_out_D0, data_out_D1, empty_fifo_D0, empty_fifo_D1,
           error_D0, error_D1, rd_pop,
    input  D0_pop, D1_pop, data_rx, src_rx, empty_rx, almost_full_rx,
           count_D0, count_D1, idle_out, active_out, error_out
  );
endinterface

// File: rtl/full_logic_drain.sv
// Consumer-side reader for the full_logic transmit path. Drains the D0/D1
// FIFOs round-robin, tags each word with its source and queues it in a small
// first-word-fall-through receive buffer for the downstream block.
module full_logic_drain #(
  parameter int data_width    = 6,
  parameter int address_width = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  full_logic_drain_if.slave     bus_io
);

  localparam int DEPTH = 1 << address_width;
  localparam logic [address_width+1:0] DEPTH_L = (address_width+2)'(DEPTH);

  localparam logic [2:0] ST_RESET  = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_IDLE   = 3'd2;
  localparam logic [2:0] ST_ACTIVE = 3'd3;
  localparam logic [2:0] ST_ERROR  = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [address_width-1:0] wr_ptr_q, rd_ptr_q;
  logic [address_width:0]   occ_q;
  logic [address_width:0]   thr_q;
  logic                     in_flight_q;
  logic                     in_flight_src_q;
  logic                     last_grant_q;
  logic [data_width:0]      mem_q [DEPTH];
  logic [7:0]               cnt0_q, cnt1_q;

  logic                     elig0_s, elig1_s, space_s, grant_s, pop_s;
  logic                     cap_s, rd_s, err_s;
  logic [data_width-1:0]    cap_data_s;
  logic [data_width:0]      head_s;

  // Pop arbitration, capture/read qualification and error detection.
  always_comb begin
    elig0_s = ~bus_io.empty_fifo_D0;
    elig1_s = ~bus_io.empty_fifo_D1;
    // A same-cycle downstream read is deliberately not credited here.
    space_s = ({1'b0, occ_q} + (address_width+2)'(in_flight_q)) < DEPTH_L;
    if (elig0_s && elig1_s) begin
      grant_s = ~last_grant_q;
    end else if (elig1_s) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    pop_s      = (state_q == ST_ACTIVE) && (elig0_s || elig1_s) && space_s;
    // The word lands one cycle after its pop; ERROR freezes the buffer.
    cap_s      = in_flight_q && (state_q != ST_ERROR) && (state_q != ST_RESET);
    cap_data_s = in_flight_src_q ? bus_io.data_out_D1 : bus_io.data_out_D0;
    rd_s       = bus_io.rd_pop && (occ_q != '0) &&
                 (state_q != ST_ERROR) && (state_q != ST_RESET);
    err_s      = bus_io.error_D0 || bus_io.error_D1 ||
                 (bus_io.rd_pop && (occ_q == '0));
  end

  // Next-state logic for the RESET/INIT/IDLE/ACTIVE/ERROR controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET: begin
        state_d = ST_INIT;
      end
      ST_INIT: begin
        if (err_s) begin
          state_d = ST_ERROR;
        end else if (!bus_io.init) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (err_s) begin
          state_d = ST_ERROR;
        end else if (bus_io.init) begin
          state_d = ST_INIT;
        end else if (elig0_s || elig1_s) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (err_s) begin
          state_d = ST_ERROR;
        end else if (!elig0_s && !elig1_s && !in_flight_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // State, buffer, pointers, occupancy, counters and arbitration history.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= ST_RESET;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
      thr_q           <= '0;
      in_flight_q     <= 1'b0;
      in_flight_src_q <= 1'b0;
      last_grant_q    <= 1'b1;
      cnt0_q          <= 8'd0;
      cnt1_q          <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_flight_q <= pop_s;
      if (state_q == ST_INIT) begin
        thr_q <= bus_io.umbral_rx;
      end
      if (pop_s) begin
        in_flight_src_q <= grant_s;
        last_grant_q    <= grant_s;
      end
      if (cap_s) begin
        mem_q[wr_ptr_q] <= {in_flight_src_q, cap_data_s};
        wr_ptr_q        <= wr_ptr_q + address_width'(1'b1);
        if (in_flight_src_q) begin
          cnt1_q <= cnt1_q + 8'd1;
        end else begin
          cnt0_q <= cnt0_q + 8'd1;
        end
      end
      if (rd_s) begin
        rd_ptr_q <= rd_ptr_q + address_width'(1'b1);
      end
      case ({cap_s, rd_s})
        2'b10:   occ_q <= occ_q + (address_width+1)'(1'b1);
        2'b01:   occ_q <= occ_q - (address_width+1)'(1'b1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Output decode: pops, FWFT head, flags, counters and status.
  always_comb begin
    head_s                = mem_q[rd_ptr_q];
    bus_io.D0_pop         = pop_s && !grant_s;
    bus_io.D1_pop         = pop_s && grant_s;
    bus_io.data_rx        = head_s[data_width-1:0];
    bus_io.src_rx         = head_s[data_width];
    bus_io.empty_rx       = (occ_q == '0);
    // Held low in RESET so a zero threshold does not raise it before init.
    bus_io.almost_full_rx = (state_q != ST_RESET) && (occ_q >= thr_q);
    bus_io.count_D0       = cnt0_q;
    bus_io.count_D1       = cnt1_q;
    bus_io.idle_out       = (state_q == ST_IDLE);
    bus_io.active_out     = (state_q == ST_ACTIVE);
    bus_io.error_out      = (state_q == ST_ERROR);
  end

endmodule

// File: tb/tb_full_logic_drain.sv
// Scoreboard bench for full_logic_drain: behavioural D0/D1 FIFOs feed the
// drain, every pop pushes the expected {src, word}, every downstream read
// pops and compares it.
module tb_full_logic_drain;
  localparam int DW = 6;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  full_logic_drain_if #(.data_width(DW), .address_width(AW)) bus ();

  full_logic_drain #(.data_width(DW), .address_width(AW)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus_io  (bus)
  );

  int            n_checks;
  int            n_errors;
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic [DW:0]   sb [$];
  bit            auto_rd;
  bit            check_alt;
  int            last_src;
  int            pop0_cnt;
  int            pop1_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample pops mid-cycle, score reads, then update the FIFO models.
  task automatic tick();
    logic        p0, p1, src;
    logic [DW:0] exp;
    logic [DW-1:0] w;
    @(negedge clk);
    if (auto_rd) bus.rd_pop = ~bus.empty_rx;
    #1;
    p0 = bus.D0_pop;
    p1 = bus.D1_pop;
    check_eq("pop_excl", 32'(p0 & p1), 32'd0);
    if (bus.rd_pop && !bus.empty_rx && !reset && !bus.error_out) begin
      if (sb.size() == 0) begin
        check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        exp = sb.pop_front();
        check_eq("rx_data", 32'(bus.data_rx), 32'(exp[DW-1:0]));
        check_eq("rx_src", 32'(bus.src_rx), 32'(exp[DW]));
      end
    end
    @(posedge clk);
    #1;
    if (p0 || p1) begin
      src = p1;
      if (check_alt && last_src >= 0) check_eq("t3_alt", 32'(src), (last_src == 0) ? 32'd1 : 32'd0);
      last_src = src ? 1 : 0;
      if (p1) begin
        w = q1.pop_front();
        bus.data_out_D1 = w;
        bus.empty_fifo_D1 = (q1.size() == 0);
        pop1_cnt++;
      end else begin
        w = q0.pop_front();
        bus.data_out_D0 = w;
        bus.empty_fifo_D0 = (q0.size() == 0);
        pop0_cnt++;
      end
      sb.push_back({src, w});
    end
  endtask

  // Watchdog so a stuck run still terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Main stimulus sequence.
  initial begin
    int first, last, done;
    logic [7:0] start0, start1;
    logic [DW-1:0] held;
    n_checks = 0; n_errors = 0;
    auto_rd = 0; check_alt = 0; last_src = -1; pop0_cnt = 0; pop1_cnt = 0;
    reset = 1'b1;
    bus.init = 1'b0; bus.umbral_rx = '0; bus.rd_pop = 1'b0;
    bus.data_out_D0 = '0; bus.data_out_D1 = '0;
    bus.empty_fifo_D0 = 1'b1; bus.empty_fifo_D1 = 1'b1;
    bus.error_D0 = 1'b0; bus.error_D1 = 1'b0;

    // 1: reset values, init with threshold 3, then IDLE
    repeat (4) tick();
    check_eq("rst_d0pop", 32'(bus.D0_pop), 32'd0);
    check_eq("rst_d1pop", 32'(bus.D1_pop), 32'd0);
    check_eq("rst_data", 32'(bus.data_rx), 32'd0);
    check_eq("rst_src", 32'(bus.src_rx), 32'd0);
    check_eq("rst_empty", 32'(bus.empty_rx), 32'd1);
    check_eq("rst_af", 32'(bus.almost_full_rx), 32'd0);
    check_eq("rst_cnt0", 32'(bus.count_D0), 32'd0);
    check_eq("rst_cnt1", 32'(bus.count_D1), 32'd0);
    check_eq("rst_idle", 32'(bus.idle_out), 32'd0);
    check_eq("rst_active", 32'(bus.active_out), 32'd0);
    check_eq("rst_error", 32'(bus.error_out), 32'd0);
    reset = 1'b0; bus.init = 1'b1; bus.umbral_rx = 3'd3;
    tick();
    check_eq("t1_in_init", 32'(bus.idle_out), 32'd0);
    tick();
    bus.init = 1'b0;
    tick();
    check_eq("t1_idle", 32'(bus.idle_out), 32'd1);
    check_eq("t1_af_empty", 32'(bus.almost_full_rx), 32'd0);

    // 2: three D0 words, no reads
    q0.push_back(6'h34); q0.push_back(6'h35); q0.push_back(6'h36);
    bus.empty_fifo_D0 = 1'b0;
    pop0_cnt = 0; pop1_cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      int b;
      b = pop0_cnt;
      tick();
      if (pop0_cnt != b) begin
        if (first < 0) first = c;
        last = c;
      end
    end
    check_eq("t2_pops", 32'(pop0_cnt), 32'd3);
    check_eq("t2_consec", 32'(last - first), 32'd2);
    check_eq("t2_d1pops", 32'(pop1_cnt), 32'd0);
    check_eq("t2_cnt0", 32'(bus.count_D0), 32'd3);
    check_eq("t2_af", 32'(bus.almost_full_rx), 32'd1);
    check_eq("t2_data", 32'(bus.data_rx), 32'h34);
    check_eq("t2_src", 32'(bus.src_rx), 32'd0);
    check_eq("t2_idle", 32'(bus.idle_out), 32'd1);

    // 3: both FIFOs busy, continuous reads, round-robin
    start0 = bus.count_D0; start1 = bus.count_D1;
    for (int i = 0; i < 8; i++) begin
      q0.push_back(DW'(i));
      q1.push_back(DW'(32 + i));
    end
    bus.empty_fifo_D0 = 1'b0; bus.empty_fifo_D1 = 1'b0;
    pop0_cnt = 0; pop1_cnt = 0; auto_rd = 1; check_alt = 1; last_src = -1; done = 0;
    for (int c = 0; c < 100 && done == 0; c++) begin
      tick();
      done = (q0.size() == 0 && q1.size() == 0 && bus.empty_rx && bus.idle_out) ? 1 : 0;
    end
    auto_rd = 0; check_alt = 0; bus.rd_pop = 1'b0;
    check_eq("t3_done", 32'(done), 32'd1);
    check_eq("t3_pops0", 32'(pop0_cnt), 32'd8);
    check_eq("t3_pops1", 32'(pop1_cnt), 32'd8);
    check_eq("t3_cnt0", 32'(8'(bus.count_D0 - start0)), 32'd8);
    check_eq("t3_cnt1", 32'(8'(bus.count_D1 - start1)), 32'd8);
    check_eq("t3_sb_left", 32'(sb.size()), 32'd0);

    // 4: no reads -> buffer fills to depth, one read frees one slot
    for (int i = 0; i < 5; i++) begin
      q0.push_back(DW'(16 + i));
      q1.push_back(DW'(24 + i));
    end
    bus.empty_fifo_D0 = 1'b0; bus.empty_fifo_D1 = 1'b0;
    pop0_cnt = 0; pop1_cnt = 0;
    repeat (12) tick();
    check_eq("t4_pops_full", 32'(pop0_cnt + pop1_cnt), 32'd4);
    check_eq("t4_af", 32'(bus.almost_full_rx), 32'd1);
    check_eq("t4_active", 32'(bus.active_out), 32'd1);
    bus.rd_pop = 1'b1;
    tick();
    bus.rd_pop = 1'b0;
    repeat (8) tick();
    check_eq("t4_pops_after", 32'(pop0_cnt + pop1_cnt), 32'd5);
    check_eq("t4_sb_size", 32'(sb.size()), 32'd4);
    check_eq("t4_head2_data", 32'(bus.data_rx), 32'(sb[0][DW-1:0]));
    check_eq("t4_head2_src", 32'(bus.src_rx), 32'(sb[0][DW]));

    // 5: error pulse during ACTIVE, frozen buffer, reset recovery
    start0 = bus.count_D0; held = bus.data_rx;
    bus.error_D1 = 1'b1;
    tick();
    bus.error_D1 = 1'b0;
    check_eq("t5_error", 32'(bus.error_out), 32'd1);
    check_eq("t5_not_active", 32'(bus.active_out), 32'd0);
    pop0_cnt = 0; pop1_cnt = 0;
    bus.rd_pop = 1'b1;
    tick();
    bus.rd_pop = 1'b0;
    repeat (4) tick();
    check_eq("t5_no_pops", 32'(pop0_cnt + pop1_cnt), 32'd0);
    check_eq("t5_frozen_data", 32'(bus.data_rx), 32'(held));
    check_eq("t5_frozen_cnt", 32'(bus.count_D0), 32'(start0));
    check_eq("t5_frozen_empty", 32'(bus.empty_rx), 32'd0);
    reset = 1'b1;
    repeat (2) tick();
    sb.delete(); q0.delete(); q1.delete();
    bus.empty_fifo_D0 = 1'b1; bus.empty_fifo_D1 = 1'b1;
    check_eq("t5_rst_error", 32'(bus.error_out), 32'd0);
    check_eq("t5_rst_empty", 32'(bus.empty_rx), 32'd1);
    check_eq("t5_rst_cnt0", 32'(bus.count_D0), 32'd0);
    check_eq("t5_rst_data", 32'(bus.data_rx), 32'd0);

    // 6: threshold 0, reset during an in-flight read, read-while-empty error
    reset = 1'b0; bus.init = 1'b1; bus.umbral_rx = 3'd0;
    repeat (2) tick();
    bus.init = 1'b0;
    tick();
    check_eq("t6_idle", 32'(bus.idle_out), 32'd1);
    check_eq("t6_af_thr0", 32'(bus.almost_full_rx), 32'd1);
    q0.push_back(6'h2A);
    bus.empty_fifo_D0 = 1'b0;
    pop0_cnt = 0;
    for (int c = 0; c < 10 && pop0_cnt == 0; c++) tick();
    check_eq("t6_pop_seen", 32'(pop0_cnt), 32'd1);
    reset = 1'b1;
    repeat (2) tick();
    sb.delete();
    check_eq("t6_cnt0", 32'(bus.count_D0), 32'd0);
    check_eq("t6_empty", 32'(bus.empty_rx), 32'd1);
    reset = 1'b0; bus.init = 1'b1; bus.umbral_rx = 3'd3;
    repeat (2) tick();
    bus.init = 1'b0;
    tick();
    check_eq("t6_idle2", 32'(bus.idle_out), 32'd1);
    bus.rd_pop = 1'b1;
    tick();
    bus.rd_pop = 1'b0;
    check_eq("t6_rd_empty_err", 32'(bus.error_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
